// File: rtl/flight_sequencer.sv
// flight_sequencer: per-IMU-sample control pass scheduler.
// One IMU strobe runs angle controller -> body-frame controller -> one mixer
// update. It watches each stage and the IMU, owns the throttle-low arming
// sequence, and holds the fault state that keeps the motors at idle.
module flight_sequencer #(
  parameter int REC_VAL_BIT_WIDTH = 8,
  parameter int THROTTLE_ARM_MAX  = 10,
  parameter int ARM_HOLD_US       = 500000,
  parameter int STAGE_TIMEOUT_US  = 2000,
  parameter int IMU_TIMEOUT_US    = 20000
) (
  input  logic                         us_clk,
  input  logic                         reset,
  input  logic                         imu_good,
  input  logic                         imu_valid_strobe,
  input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
  input  logic                         ac_complete,
  input  logic                         bf_complete,
  output logic                         ac_start,
  output logic                         bf_start,
  output logic                         mixer_update,
  output logic                         motors_enable,
  output logic                         armed,
  output logic                         fault,
  output logic [2:0]                   fault_code,
  output logic [7:0]                   overrun_count
);

  localparam int ARM_W   = $clog2(ARM_HOLD_US + 1);
  localparam int STAGE_W = $clog2(STAGE_TIMEOUT_US + 1);
  localparam int IMU_W   = $clog2(IMU_TIMEOUT_US + 1);

  localparam logic [REC_VAL_BIT_WIDTH-1:0] THROTTLE_MAX = REC_VAL_BIT_WIDTH'(THROTTLE_ARM_MAX);
  localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(ARM_HOLD_US - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_TIMEOUT_US - 1);
  localparam logic [IMU_W-1:0]   IMU_LAST   = IMU_W'(IMU_TIMEOUT_US - 1);
  localparam logic [IMU_W-1:0]   IMU_SAT    = IMU_W'(IMU_TIMEOUT_US);

  localparam logic [2:0] CODE_AC  = 3'd1;
  localparam logic [2:0] CODE_BF  = 3'd2;
  localparam logic [2:0] CODE_IMU = 3'd3;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_WAIT_AC,
    SEQ_WAIT_BF,
    SEQ_UPDATE,
    SEQ_FAULT
  } seq_state_t;

  typedef enum logic [1:0] {
    ARM_DISARMED,
    ARM_ARMING,
    ARM_ARMED
  } arm_state_t;

  seq_state_t          seq_state, seq_next;
  arm_state_t          arm_state, arm_next;
  logic [ARM_W-1:0]    arm_cnt, arm_cnt_next;
  logic [STAGE_W-1:0]  stage_timer;
  logic [IMU_W-1:0]    imu_timer;
  logic [2:0]          fault_code_next;
  logic                stick_low;
  logic                imu_fault;
  logic                in_wait;

  assign stick_low = (throttle_val <= THROTTLE_MAX);
  assign in_wait   = (seq_state == SEQ_WAIT_AC) || (seq_state == SEQ_WAIT_BF);
  // The IMU is stale once the gap reaches its limit with no strobe arriving now.
  assign imu_fault = !imu_good || (!imu_valid_strobe && (imu_timer >= IMU_LAST));

  // Sequencer next-state: pass progression, stage timeouts, IMU fault override.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    seq_next        = seq_state;
    fault_code_next = fault_code;
    case (seq_state)
      SEQ_IDLE: begin
        if (imu_valid_strobe) seq_next = SEQ_WAIT_AC;
      end
      SEQ_WAIT_AC: begin
        if (ac_complete) begin
          seq_next = SEQ_WAIT_BF;
        end else if (stage_timer == STAGE_LAST) begin
          seq_next        = SEQ_FAULT;
          fault_code_next = CODE_AC;
        end
      end
      SEQ_WAIT_BF: begin
        if (bf_complete) begin
          seq_next = SEQ_UPDATE;
        end else if (stage_timer == STAGE_LAST) begin
          seq_next        = SEQ_FAULT;
          fault_code_next = CODE_BF;
        end
      end
      SEQ_UPDATE: begin
        seq_next = SEQ_IDLE;
      end
      SEQ_FAULT: begin
        // The recovery strobe is consumed here and never starts a pass.
        if (imu_good && imu_valid_strobe && stick_low) seq_next = SEQ_IDLE;
      end
      default: begin
        seq_next = SEQ_IDLE;
      end
    endcase
    // IMU problems outrank stage timeouts raised in the same cycle.
    if ((seq_state != SEQ_FAULT) && imu_fault) begin
      seq_next        = SEQ_FAULT;
      fault_code_next = CODE_IMU;
    end
  end

  // Arming next-state: hold stick low long enough to arm; any fault disarms.
  always_comb begin
    arm_next     = arm_state;
    arm_cnt_next = arm_cnt;
    case (arm_state)
      ARM_DISARMED: begin
        if (stick_low && imu_good && (seq_state != SEQ_FAULT)) begin
          arm_next     = ARM_ARMING;
          arm_cnt_next = '0;
        end
      end
      ARM_ARMING: begin
        if (!stick_low) begin
          arm_next     = ARM_DISARMED;
          arm_cnt_next = '0;
        end else if (arm_cnt == ARM_LAST) begin
          arm_next = ARM_ARMED;
        end else begin
          arm_cnt_next = arm_cnt + 1'b1;
        end
      end
      ARM_ARMED: begin
        arm_next = ARM_ARMED;
      end
      default: begin
        arm_next     = ARM_DISARMED;
        arm_cnt_next = '0;
      end
    endcase
    // Being in, or entering, FAULT always wins over arm completion.
    if (seq_next == SEQ_FAULT) begin
      arm_next     = ARM_DISARMED;
      arm_cnt_next = '0;
    end
  end

  // State registers for both FSMs.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      seq_state <= SEQ_IDLE;
      arm_state <= ARM_DISARMED;
      arm_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      seq_state <= seq_next;
      arm_state <= arm_next;
      arm_cnt   <= arm_cnt_next;
    end
  end

  // Stage timer: zero on the start-pulse cycle of each stage, counts while waiting.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      stage_timer <= '0;
    end else if ((seq_next != seq_state) &&
                 ((seq_next == SEQ_WAIT_AC) || (seq_next == SEQ_WAIT_BF))) begin
      stage_timer <= '0;
    end else if (in_wait) begin
      stage_timer <= stage_timer + 1'b1;
    end
  end

  // IMU watchdog: cycles since the last strobe, saturating.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      imu_timer <= '0;
    end else if (imu_valid_strobe) begin
      imu_timer <= '0;
    end else if (imu_timer != IMU_SAT) begin
      imu_timer <= imu_timer + 1'b1;
    end
  end

  // Overrun counter: strobes dropped mid-pass, saturating at 255.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      overrun_count <= '0;
    end else if (imu_valid_strobe && (in_wait || (seq_state == SEQ_UPDATE)) &&
                 (overrun_count != 8'hFF)) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      ac_start      <= 1'b0;
      bf_start      <= 1'b0;
      mixer_update  <= 1'b0;
      motors_enable <= 1'b0;
      armed         <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 3'd0;
    end else begin
      ac_start      <= (seq_state == SEQ_IDLE) && (seq_next == SEQ_WAIT_AC);
      bf_start      <= (seq_state == SEQ_WAIT_AC) && (seq_next == SEQ_WAIT_BF);
      mixer_update  <= (seq_next == SEQ_UPDATE);
      motors_enable <= (arm_next == ARM_ARMED) && (seq_next != SEQ_FAULT);
      armed         <= (arm_next == ARM_ARMED);
      fault         <= (seq_next == SEQ_FAULT);
      fault_code    <= fault_code_next;
    end
  end

endmodule

// File: tb/tb_flight_sequencer.sv
// Directed bench for flight_sequencer with short timeouts so every path is reachable.
module tb_flight_sequencer;

  localparam int ARM_HOLD = 16;
  localparam int STAGE_TO = 8;
  localparam int IMU_TO   = 32;
  localparam int THR_MAX  = 10;

  logic       us_clk;
  logic       reset;
  logic       imu_good;
  logic       imu_valid_strobe;
  logic [7:0] throttle_val;
  logic       ac_complete;
  logic       bf_complete;
  logic       ac_start;
  logic       bf_start;
  logic       mixer_update;
  logic       motors_enable;
  logic       armed;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] overrun_count;

  int n_cmp = 0;
  int n_bad = 0;

  flight_sequencer #(
    .REC_VAL_BIT_WIDTH(8),
    .THROTTLE_ARM_MAX (THR_MAX),
    .ARM_HOLD_US      (ARM_HOLD),
    .STAGE_TIMEOUT_US (STAGE_TO),
    .IMU_TIMEOUT_US   (IMU_TO)
  ) dut (
    .us_clk          (us_clk),
    .reset           (reset),
    .imu_good        (imu_good),
    .imu_valid_strobe(imu_valid_strobe),
    .throttle_val    (throttle_val),
    .ac_complete     (ac_complete),
    .bf_complete     (bf_complete),
    .ac_start        (ac_start),
    .bf_start        (bf_start),
    .mixer_update    (mixer_update),
    .motors_enable   (motors_enable),
    .armed           (armed),
    .fault           (fault),
    .fault_code      (fault_code),
    .overrun_count   (overrun_count)
  );

  initial us_clk = 1'b0;
  always #5 us_clk = ~us_clk;

  // {ac_start, bf_start, mixer_update, motors_enable, armed, fault}
  function automatic logic [5:0] obs_vec();
    return {ac_start, bf_start, mixer_update, motors_enable, armed, fault};
  endfunction

  // Advance one cycle; outputs are then read 1 ns after the edge.
  task automatic tick();
    @(posedge us_clk);
    #1;
  endtask

  task automatic clear_inputs();
    imu_valid_strobe = 1'b0;
    ac_complete      = 1'b0;
    bf_complete      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    imu_good     = 1'b1;
    throttle_val = 8'd200;
    repeat (2) @(posedge us_clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    imu_good     = 1'b1;
    throttle_val = 8'd200;
    repeat (2) @(posedge us_clk);
    #1;
    n_cmp++;
    if ({obs_vec(), fault_code, overrun_count} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_held got %b want 0", {obs_vec(), fault_code, overrun_count});
    end
    reset = 1'b0;
    n_cmp++;
    if ({obs_vec(), fault_code, overrun_count} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_release got %b want 0", {obs_vec(), fault_code, overrun_count});
    end
    tick();
    n_cmp++;
    if ({obs_vec(), fault_code, overrun_count} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_idle got %b want 0", {obs_vec(), fault_code, overrun_count});
    end
  endtask

  // Strobe every 20 cycles, completes 2 cycles after each start.
  // Throttle is lo_val except one high cycle at abort_at; arming expected from arm_from.
  task automatic run_schedule(input string name, input int ncyc, input int abort_at,
                              input int arm_from, input logic [7:0] lo_val);
    logic [5:0] exp;
    for (int t = 0; t < ncyc; t++) begin
      exp = {(t % 20) == 1, (t % 20) == 4, (t % 20) == 7, t >= arm_from, t >= arm_from, 1'b0};
      n_cmp++;
      if (obs_vec() !== exp) begin
        n_bad++;
        $display("FAIL %s t=%0d outputs got %b want %b", name, t, obs_vec(), exp);
      end
      imu_valid_strobe = ((t % 20) == 0);
      ac_complete      = ((t % 20) == 3);
      bf_complete      = ((t % 20) == 6);
      throttle_val     = (t == abort_at) ? 8'd11 : lo_val;
      tick();
    end
    clear_inputs();
  endtask

  task automatic arm_up();
    do_reset();
    run_schedule("arm_up", 20, -1, 17, 8'd5);
  endtask

  task automatic test_nominal();
    do_reset();
    run_schedule("nominal", 60, -1, 17, 8'd5);
    n_cmp++;
    if ({fault_code, overrun_count} !== 11'd0) begin
      n_bad++;
      $display("FAIL nominal_status got code=%0d ovr=%0d want 0/0", fault_code, overrun_count);
    end
  endtask

  task automatic test_arm_abort();
    do_reset();
    run_schedule("arm_abort", 36, 10, 28, 8'd5);
  endtask

  task automatic test_throttle_edge();
    do_reset();
    run_schedule("thr_at_max", 20, -1, 17, 8'd10);
    do_reset();
    run_schedule("thr_above_max", 20, -1, 999, 8'd11);
  endtask

  // One armed pass starting with a strobe at s=0.
  task automatic run_pass(input string name, input int ac_at, input int bf_at, input int imu_bad_at,
                          input int n, input int exp_bf, input int exp_mx,
                          input int fault_from, input logic [2:0] code);
    logic [5:0] exp;
    logic [2:0] exp_code;
    arm_up();
    for (int s = 0; s < n; s++) begin
      exp = {s == 1, s == exp_bf, s == exp_mx, s < fault_from, s < fault_from, s >= fault_from};
      exp_code = (s >= fault_from) ? code : 3'd0;
      n_cmp++;
      if ({obs_vec(), fault_code} !== {exp, exp_code}) begin
        n_bad++;
        $display("FAIL %s s=%0d outs/code got %b/%0d want %b/%0d",
                 name, s, obs_vec(), fault_code, exp, exp_code);
      end
      imu_valid_strobe = (s == 0);
      ac_complete      = (s == ac_at);
      bf_complete      = (s == bf_at);
      imu_good         = (s != imu_bad_at);
      tick();
    end
    clear_inputs();
    imu_good = 1'b1;
  endtask

  task automatic test_stage_timeout();
    run_pass("ac_timeout",    -1, -1, -1, 11, -1, -1,  9, 3'd1);
    run_pass("ac_last_ofs",    8, 11, -1, 15,  9, 12, 99, 3'd0);
    run_pass("imu_beats_ac",  -1, -1,  8, 11, -1, -1,  9, 3'd3);
    run_pass("bf_timeout",     2, -1, -1, 13,  3, -1, 11, 3'd2);
    run_pass("bf_last_ofs",    2, 10, -1, 13,  3, 11, 99, 3'd0);
  endtask

  task automatic test_overrun();
    logic [5:0] exp;
    int mixer_pulses;
    arm_up();
    for (int s = 0; s < 12; s++) begin
      exp = {s == 1, s == 4, s == 7, 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if ({obs_vec(), overrun_count} !== {exp, (s >= 6) ? 8'd1 : 8'd0}) begin
        n_bad++;
        $display("FAIL overrun s=%0d outs/ovr got %b/%0d want %b/%0d",
                 s, obs_vec(), overrun_count, exp, (s >= 6) ? 1 : 0);
      end
      imu_valid_strobe = (s == 0) || (s == 5);
      ac_complete      = (s == 3);
      bf_complete      = (s == 6);
      tick();
    end
    // Back-to-back minimum passes with a strobe every cycle: 3 drops per 4 cycles.
    mixer_pulses = 0;
    imu_valid_strobe = 1'b1;
    ac_complete      = 1'b1;
    bf_complete      = 1'b1;
    for (int p = 0; p < 400; p++) begin
      if (mixer_update === 1'b1) mixer_pulses++;
      tick();
    end
    clear_inputs();
    n_cmp++;
    if (mixer_pulses != 100) begin
      n_bad++;
      $display("FAIL back_to_back mixer pulses got %0d want 100", mixer_pulses);
    end
    n_cmp++;
    if ({overrun_count, fault} !== {8'd255, 1'b0}) begin
      n_bad++;
      $display("FAIL overrun_sat got ovr=%0d fault=%b want 255/0", overrun_count, fault);
    end
  endtask

  task automatic test_imu_fault();
    logic [5:0] exp;
    logic       exp_arm;
    logic       exp_flt;
    arm_up();
    for (int s = 0; s < 26; s++) begin
      exp_arm = (s < 1) || (s >= 23);
      exp_flt = (s >= 1) && (s <= 5);
      exp = {1'b0, 1'b0, 1'b0, exp_arm, exp_arm, exp_flt};
      n_cmp++;
      if ({obs_vec(), fault_code, overrun_count} !==
          {exp, (s >= 1) ? 3'd3 : 3'd0, 8'd0}) begin
        n_bad++;
        $display("FAIL imu_fault s=%0d outs/code/ovr got %b/%0d/%0d want %b/%0d/0",
                 s, obs_vec(), fault_code, overrun_count, exp, (s >= 1) ? 3 : 0);
      end
      imu_good         = (s != 0);
      imu_valid_strobe = (s == 3) || (s == 5);
      throttle_val     = (s == 3) ? 8'd11 : 8'd5;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_imu_stale();
    do_reset();
    for (int t = 0; t < 34; t++) begin
      n_cmp++;
      if ({fault, fault_code} !== {t >= 32, (t >= 32) ? 3'd3 : 3'd0}) begin
        n_bad++;
        $display("FAIL imu_stale t=%0d fault/code got %b/%0d want %b/%0d",
                 t, fault, fault_code, t >= 32, (t >= 32) ? 3 : 0);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int t = 0; t < 26; t++) begin
      if (t == 1) begin
        n_cmp++;
        if ({fault, fault_code} !== 4'b1011) begin
          n_bad++;
          $display("FAIL ar_fault got %b/%0d want 1/3", fault, fault_code);
        end
      end
      if (t == 3) begin
        n_cmp++;
        if ({fault, fault_code} !== 4'b0011) begin
          n_bad++;
          $display("FAIL ar_recover got %b/%0d want 0/3", fault, fault_code);
        end
      end
      if (t >= 3) begin
        n_cmp++;
        if (armed !== (t >= 20)) begin
          n_bad++;
          $display("FAIL ar_rearm t=%0d armed got %b want %b", t, armed, t >= 20);
        end
      end
      imu_good         = (t != 0);
      imu_valid_strobe = (t == 2) || (t == 25);
      throttle_val     = (t >= 2) ? 8'd5 : 8'd200;
      tick();
    end
    clear_inputs();
    n_cmp++;
    if ({ac_start, armed, fault_code} !== 5'b11011) begin
      n_bad++;
      $display("FAIL ar_wait_ac got %b want 11011", {ac_start, armed, fault_code});
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({obs_vec(), fault_code, overrun_count} !== 17'd0) begin
      n_bad++;
      $display("FAIL ar_async got %b want 0", {obs_vec(), fault_code, overrun_count});
    end
    @(posedge us_clk);
    #1 reset = 1'b0;
    n_cmp++;
    if ({obs_vec(), fault_code} !== 9'd0) begin
      n_bad++;
      $display("FAIL ar_release got %b want 0", {obs_vec(), fault_code});
    end
    imu_valid_strobe = 1'b1;
    tick();
    imu_valid_strobe = 1'b0;
    n_cmp++;
    if ({obs_vec(), fault_code} !== {6'b100000, 3'd0}) begin
      n_bad++;
      $display("FAIL ar_restart got %b want 100000000", {obs_vec(), fault_code});
    end
  endtask

  initial begin
    reset            = 1'b1;
    imu_good         = 1'b1;
    imu_valid_strobe = 1'b0;
    throttle_val     = 8'd200;
    ac_complete      = 1'b0;
    bf_complete      = 1'b0;
    test_reset();
    test_nominal();
    test_arm_abort();
    test_throttle_edge();
    test_stage_timeout();
    test_overrun();
    test_imu_fault();
    test_imu_stale();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
